// File: rtl/vec_pkg.sv
// Shared definitions for the vector pixel loader.
// Holds the default geometry constants, the loader FSM state encoding and
// the pixel/address element types.
package vec_pkg;

  localparam int PIXEL_W    = 8;
  localparam int ADDR_W     = 24;
  localparam int VEC_LANES  = 4;
  localparam int IMG_PIXELS = 90000;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD,
    DONE
  } loader_state_t;

  typedef logic [PIXEL_W-1:0] pixel_t;
  typedef logic [ADDR_W-1:0]  addr_t;

endpackage

// File: rtl/vec_lane_packer.sv
// Vector pack register: LANES lanes of PIXEL bits each.
// Ports:
//   clk, rst  - clock and synchronous active-high reset
//   clr       - synchronous clear of all lanes (has priority over wr_en)
//   wr_en     - write wr_data into lane wr_lane
//   wr_lane   - target lane index
//   wr_data   - pixel to store
//   data      - packed vector, lane i at bits [i*PIXEL +: PIXEL]
module vec_lane_packer #(
  parameter int PIXEL = 8,
  parameter int LANES = 4,
  parameter int LW    = $clog2(LANES)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   wr_en,
  input  logic [LW-1:0]          wr_lane,
  input  logic [PIXEL-1:0]       wr_data,
  output logic [LANES*PIXEL-1:0] data
);

  logic [LANES*PIXEL-1:0] data_q, data_d;

  always_comb begin
    data_d = data_q;
    if (clr) begin
      data_d = '0;
    end else if (wr_en) begin
      data_d[wr_lane*PIXEL +: PIXEL] = wr_data;
    end
  end

  // NOTE: state is updated with non-blocking assignments only, so every flop
  // samples values from before the edge regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) data_q <= '0;
    else     data_q <= data_d;
  end

  assign data = data_q;

endmodule

// File: rtl/vec_pixel_loader.sv
// Walks a pixel range in the pixel input memory, one address per cycle, and
// packs LANES consecutive pixels into a vector word handed downstream over a
// valid/ready handshake. The final partial vector is zero padded and flagged.
// Ports:
//   clk, rst            - clock and synchronous active-high reset
//   start               - begin a load (only honoured in IDLE)
//   base_addr, count    - first pixel address and pixel count
//   mem_addr, mem_rd    - pixel memory address out / combinational read data in
//   vec_data, vec_valid,
//   vec_ready, vec_last - vector output handshake
//   busy, done          - status: not idle / one-cycle completion pulse
module vec_pixel_loader
  import vec_pkg::*;
#(
  parameter int WIDTH = ADDR_W,
  parameter int PIXEL = PIXEL_W,
  parameter int LANES = VEC_LANES
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [WIDTH-1:0]       base_addr,
  input  logic [WIDTH-1:0]       count,
  output logic [WIDTH-1:0]       mem_addr,
  input  logic [WIDTH-1:0]       mem_rd,
  output logic [LANES*PIXEL-1:0] vec_data,
  output logic                   vec_valid,
  input  logic                   vec_ready,
  output logic                   vec_last,
  output logic                   busy,
  output logic                   done
);

  localparam int LW = $clog2(LANES);

  loader_state_t    state_q, state_d;
  logic [WIDTH-1:0] base_q, base_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] idx_q, idx_d;
  logic [LW-1:0]    lane_q, lane_d;
  logic             last_q, last_d;
  logic             pk_clr, pk_wr;
  logic             fetch_last;

  // Current capture is the final pixel of the range.
  assign fetch_last = (idx_q == count_q - WIDTH'(1));

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    count_d = count_q;
    idx_d   = idx_q;
    lane_d  = lane_q;
    last_d  = last_q;
    pk_clr  = 1'b0;
    pk_wr   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          base_d  = base_addr;
          count_d = count;
          idx_d   = '0;
          lane_d  = '0;
          last_d  = 1'b0;
          pk_clr  = 1'b1;
          state_d = (count == '0) ? DONE : FETCH;
        end
      end
      FETCH: begin
        pk_wr  = 1'b1;
        idx_d  = idx_q + WIDTH'(1);
        lane_d = lane_q + LW'(1);
        if (lane_q == LW'(LANES - 1) || fetch_last) begin
          last_d  = fetch_last;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (vec_ready) begin
          if (last_q) begin
            last_d  = 1'b0;
            state_d = DONE;
          end else begin
            pk_clr  = 1'b1;
            lane_d  = '0;
            state_d = FETCH;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      base_q  <= '0;
      count_q <= '0;
      idx_q   <= '0;
      lane_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      lane_q  <= lane_d;
      last_q  <= last_d;
    end
  end

  // In HOLD idx has already advanced past the last capture, so step back one
  // to keep the address steady while the vector waits.
  always_comb begin
    mem_addr = '0;
    case (state_q)
      FETCH:   mem_addr = base_q + idx_q;
      HOLD:    mem_addr = base_q + idx_q - WIDTH'(1);
      default: mem_addr = '0;
    endcase
  end

  vec_lane_packer #(
    .PIXEL (PIXEL),
    .LANES (LANES),
    .LW    (LW)
  ) u_packer (
    .clk     (clk),
    .rst     (rst),
    .clr     (pk_clr),
    .wr_en   (pk_wr),
    .wr_lane (lane_q),
    .wr_data (mem_rd[PIXEL-1:0]),
    .data    (vec_data)
  );

  assign vec_valid = (state_q == HOLD);
  assign vec_last  = last_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);

endmodule

// File: tb/tb_vec_pixel_loader.sv
// Directed bench for vec_pixel_loader (LANES=4). The memory model returns
// {fill, addr[7:0]}; expected vectors in the table are hand computed.
module tb_vec_pixel_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [23:0] base_addr;
  logic [23:0] count;
  logic [23:0] mem_addr;
  logic [23:0] mem_rd;
  logic [31:0] vec_data;
  logic        vec_valid;
  logic        vec_ready;
  logic        vec_last;
  logic        busy;
  logic        done;
  logic [15:0] fill;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign mem_rd = {fill, mem_addr[7:0]};

  vec_pixel_loader #(
    .WIDTH (24),
    .PIXEL (8),
    .LANES (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .count     (count),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .vec_data  (vec_data),
    .vec_valid (vec_valid),
    .vec_ready (vec_ready),
    .vec_last  (vec_last),
    .busy      (busy),
    .done      (done)
  );

  typedef struct {
    logic [23:0] base;
    logic [23:0] cnt;
    int          delay;   // cycles vec_ready stays low after valid
    logic [15:0] fill;    // upper memory bits, must be ignored
    bit          poke;    // fire a spurious start mid-FETCH
    logic [31:0] v0;
    logic [31:0] v1;
  } row_t;

  row_t rows[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, " busy"},  32'(busy), 32'd0);
    check({tag, " done"},  32'(done), 32'd0);
    check({tag, " valid"}, 32'(vec_valid), 32'd0);
    check({tag, " addr"},  32'(mem_addr), 32'd0);
  endtask

  task automatic run_row(input int id, input row_t r);
    int          nvec;
    int          nl;
    logic [31:0] ev;
    logic [23:0] ea;
    nvec      = (int'(r.cnt) + 3) / 4;
    fill      = r.fill;
    vec_ready = (r.delay == 0);
    @(negedge clk);
    start     = 1'b1;
    base_addr = r.base;
    count     = r.cnt;
    for (int j = 0; j < nvec; j++) begin
      nl = (int'(r.cnt) - 4 * j > 4) ? 4 : int'(r.cnt) - 4 * j;
      ev = (j == 0) ? r.v0 : r.v1;
      for (int k = 0; k < nl; k++) begin
        @(negedge clk);
        start = 1'b0;
        ea    = r.base + 24'(4 * j + k);
        check($sformatf("r%0d v%0d fetch%0d addr", id, j, k), 32'(mem_addr), 32'(ea));
        check($sformatf("r%0d v%0d fetch%0d valid", id, j, k), 32'(vec_valid), 32'd0);
        if (r.poke && j == 0 && k == 1) begin
          start     = 1'b1;
          base_addr = 24'h000050;
          count     = 24'd1;
        end
      end
      ea = r.base + 24'(4 * j + nl - 1);
      @(negedge clk);
      check($sformatf("r%0d v%0d valid", id, j), 32'(vec_valid), 32'd1);
      check($sformatf("r%0d v%0d data", id, j), vec_data, ev);
      check($sformatf("r%0d v%0d last", id, j), 32'(vec_last), 32'(j == nvec - 1));
      check($sformatf("r%0d v%0d busy", id, j), 32'(busy), 32'd1);
      if (r.delay > 0) begin
        for (int d = 1; d < r.delay; d++) begin
          @(negedge clk);
          check($sformatf("r%0d hold%0d valid", id, d), 32'(vec_valid), 32'd1);
          check($sformatf("r%0d hold%0d data", id, d), vec_data, ev);
          check($sformatf("r%0d hold%0d addr", id, d), 32'(mem_addr), 32'(ea));
        end
        vec_ready = 1'b1;
      end
    end
    @(negedge clk);
    check($sformatf("r%0d done", id), 32'(done), 32'd1);
    check($sformatf("r%0d done busy", id), 32'(busy), 32'd1);
    check($sformatf("r%0d done valid", id), 32'(vec_valid), 32'd0);
    @(negedge clk);
    check_idle($sformatf("r%0d after", id));
    vec_ready = 1'b1;
  endtask

  initial begin
    rows[0] = '{base: 24'd0,       cnt: 24'd8, delay: 0, fill: 16'h0000, poke: 1'b0,
                v0: 32'h03020100, v1: 32'h07060504};
    rows[1] = '{base: 24'd300,     cnt: 24'd6, delay: 0, fill: 16'h0000, poke: 1'b0,
                v0: 32'h2F2E2D2C, v1: 32'h00003130};
    rows[2] = '{base: 24'd0,       cnt: 24'd4, delay: 5, fill: 16'h0000, poke: 1'b0,
                v0: 32'h03020100, v1: 32'h0};
    rows[3] = '{base: 24'd0,       cnt: 24'd8, delay: 0, fill: 16'hFFFF, poke: 1'b0,
                v0: 32'h03020100, v1: 32'h07060504};
    rows[4] = '{base: 24'd0,       cnt: 24'd8, delay: 0, fill: 16'h0000, poke: 1'b1,
                v0: 32'h03020100, v1: 32'h07060504};
    rows[5] = '{base: 24'hFFFFFE,  cnt: 24'd3, delay: 0, fill: 16'h0000, poke: 1'b0,
                v0: 32'h0000FFFE, v1: 32'h0};
    rows[6] = '{base: 24'd5,       cnt: 24'd1, delay: 2, fill: 16'hA5A5, poke: 1'b0,
                v0: 32'h00000005, v1: 32'h0};

    rst       = 1'b1;
    start     = 1'b0;
    base_addr = '0;
    count     = '0;
    vec_ready = 1'b1;
    fill      = '0;
    repeat (2) @(negedge clk);
    check_idle("reset");
    check("reset data", vec_data, 32'd0);
    check("reset last", 32'(vec_last), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) run_row(i, rows[i]);

    // count == 0: straight to DONE, no vector.
    @(negedge clk);
    start = 1'b1;
    count = 24'd0;
    base_addr = 24'd77;
    @(negedge clk);
    start = 1'b0;
    check("zero done", 32'(done), 32'd1);
    check("zero busy", 32'(busy), 32'd1);
    check("zero valid", 32'(vec_valid), 32'd0);
    @(negedge clk);
    check_idle("zero after");

    // Reset while a vector is held.
    vec_ready = 1'b0;
    fill      = 16'h0000;
    start     = 1'b1;
    base_addr = 24'd0;
    count     = 24'd8;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("prerst valid", 32'(vec_valid), 32'd1);
    check("prerst data", vec_data, 32'h03020100);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle("midrst");
    check("midrst data", vec_data, 32'd0);
    check("midrst last", 32'(vec_last), 32'd0);
    vec_ready = 1'b1;

    // Fresh range after the reset.
    run_row(10, rows[1]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/vec_pixel_loader.md
Name: vec_pixel_loader

Overview:
- Stage directly downstream of the pixel input memory (24-bit address in, 24-bit zero-extended 8-bit pixel out, combinational read).
- Walks a pixel range sequentially and drives one address per cycle.
- Packs LANES consecutive pixels into one vector word and hands it to the vector pipeline over a valid/ready handshake.
- Pads the final partial vector with zeros and flags the last vector of the range.

Parameters:
- WIDTH, 24, address width and memory read-data width.
- PIXEL, 8, bits per pixel; only mem_rd[PIXEL-1:0] is used.
- LANES, 4, pixels per vector word (power of two, 2..16).

Ports:
- clk  in  1  system clock, all state updates on posedge.
- rst  in  1  synchronous active-high reset.
- start  in  1  pulse: begin a load; sampled only in IDLE.
- base_addr  in  WIDTH  first pixel address, captured on accepted start.
- count  in  WIDTH  number of pixels to load, captured on accepted start.
- mem_addr  out  WIDTH  address to the pixel input memory.
- mem_rd  in  WIDTH  read data from the pixel input memory; upper WIDTH-PIXEL bits ignored.
- vec_data  out  LANES*PIXEL  packed vector; lane i occupies bits [i*PIXEL +: PIXEL], lane 0 is the lowest address.
- vec_valid  out  1  vec_data/vec_last are valid.
- vec_ready  in  1  consumer accepts the vector.
- vec_last  out  1  the current vector is the final one of the range.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when the range completes.

Behaviour:
- States: IDLE, FETCH, HOLD, DONE.
- Reset (synchronous, any state, including mid-operation):
  - state=IDLE.
  - idx=0, lane=0, pack register=0.
  - Outputs: mem_addr=0, vec_data=0, vec_valid=0, vec_last=0, busy=0, done=0.
- IDLE:
  - mem_addr=0.
  - On start: capture base_addr and count, set idx=0 and lane=0, clear the pack register.
  - If count==0, go to DONE; otherwise go to FETCH.
- FETCH:
  - mem_addr = base_reg + idx, combinational from registers; the sum wraps modulo 2^WIDTH with no range check.
  - At each posedge, pack[lane] <= mem_rd[PIXEL-1:0], then idx++ and lane++.
  - If lane==LANES-1 or idx==count_reg-1, go to HOLD.
  - vec_last is registered as (idx==count_reg-1) on that final capture.
- Lanes not written before HOLD remain zero; the pack register is cleared on entry to FETCH.
- HOLD:
  - vec_valid=1; vec_data and vec_last are driven from registers and must stay stable until accepted.
  - mem_addr holds its last value; no fetch occurs.
  - On vec_valid && vec_ready: if vec_last, go to DONE; otherwise clear pack, set lane=0, go to FETCH.
- DONE:
  - done=1 for exactly one cycle; busy stays high in this cycle; next state is IDLE.
- Latency:
  - Start accepted at edge E0; the first vector is valid in the cycle after edge E0+LANES.
  - Throughput is LANES+1 cycles per vector when vec_ready is held high.
- start outside IDLE is ignored, and base_addr/count changes are ignored while busy.
- vec_ready while vec_valid=0 has no effect.
- Counters are WIDTH bits wide; count up to 2^WIDTH-1 is supported.

Decomposition:
- Package vec_pkg:
  - Constants PIXEL_W=8, ADDR_W=24, VEC_LANES=4, IMG_PIXELS=90000.
  - Typedef loader_state_t enum {IDLE, FETCH, HOLD, DONE}.
  - Typedefs pixel_t and addr_t.
- One natural sub-module: vec_lane_packer.
  - Holds the LANES×PIXEL register with per-lane write enable and synchronous clear.
  - The top level keeps the FSM, counters and address adder.

Test Plan (LANES=4, memory model returns {16'b0, addr[7:0]}):
- base=0, count=8, ready=1:
  - mem_addr sequence is 0..3, then 4..7.
  - vec_data=0x03020100 with last=0, then 0x07060504 with last=1.
  - done pulses one cycle after the second handshake.
- base=300, count=6:
  - Vectors are 0x2F2E2D2C, then 0x00003130 with last=1; unused lanes are zero.
- Backpressure: count=4, ready held low 5 cycles after valid.
  - vec_data=0x03020100 and mem_addr stay constant; the vector is accepted on the first ready cycle; done follows.
- count=0 start: no vec_valid; done=1 in the cycle after the start edge; busy high only that cycle.
- Memory model drives upper 16 bits = 0xFFFF: vec_data unchanged versus scenario 1.
- Robustness:
  - A second start mid-FETCH is ignored; the output matches scenario 1.
  - rst asserted in the middle of HOLD gives all outputs 0 next cycle and state IDLE.
  - A new start afterwards produces a correct fresh range.
